// File: rtl/bg_parallax_starfield.sv
// Two-layer parallax starfield background over a two-band sky, for the bg2 slot of the colour mux.
// Latency: one cycle; the RGB at cycle n+1 reflects pix_x/pix_y/video_active/bg_en at cycle n.
// Backpressure: none; the block is free-running and produces one pixel every clock.
//
// Ports:
//   clk, rst_n        pixel clock and asynchronous active-low reset
//   bg_en             layer enable; when low, the output is black and the scroll/twinkle state is frozen
//   video_active      visible-area flag; when low, the output is black
//   pix_x, pix_y      current pixel column and row (10 bit)
//   vsync             positive-polarity vertical sync; its rising edge advances the frame
//   R, G, B           2-bit colour channels to the layer-select mux
module bg_parallax_starfield #(
  parameter logic [5:0]  SEED_NEAR = 6'h15,
  parameter logic [5:0]  SEED_FAR  = 6'h2A,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [9:0]  SKY_SPLIT = 10'd384
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bg_en,
  input  logic       video_active,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       vsync,
  output logic [1:0] R,
  output logic [1:0] G,
  output logic [1:0] B
);

  logic        vsync_q;
  logic [9:0]  frame_cnt_q, frame_cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [5:0]  rgb_q, rgb_d;

  logic        frame_tick;
  logic [9:0]  off_near;
  logic [9:0]  sx_near, sx_far;
  logic [5:0]  cy_swz;
  logic [5:0]  key_near, key_far;
  logic        hit_near, hit_far;

  // Advance only while enabled; a disabled layer freezes and resumes without catching up.
  assign frame_tick = vsync & ~vsync_q & bg_en;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    lfsr_d      = lfsr_q;
    if (frame_tick) begin
      frame_cnt_d = frame_cnt_q + 10'd1;
      lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  // The near layer scrolls twice as fast; the shift drops the top bit so it wraps mod 1024.
  assign off_near = {frame_cnt_q[8:0], 1'b0};
  assign sx_near  = pix_x + off_near;
  assign sx_far   = pix_x + frame_cnt_q;

  // Row-cell index with its halves swapped, so the hash does not repeat down the screen
  // with the same period as across it.
  assign cy_swz   = {pix_y[6:4], pix_y[9:7]};
  assign key_near = sx_near[9:4] ^ cy_swz ^ SEED_NEAR;
  assign key_far  = sx_far[9:4]  ^ cy_swz ^ SEED_FAR;

  // One cell in eight carries a star; its position inside the 16x16 cell comes from the
  // low key bits (column 4..11, row 7..0).
  assign hit_near = (key_near[5:3] == 3'd0) &&
                    (sx_near[3:0] == ({1'b0, key_near[2:0]} + 4'd4)) &&
                    (pix_y[3:0]   == {1'b0, ~key_near[2:0]});
  assign hit_far  = (key_far[5:3] == 3'd0) &&
                    (sx_far[3:0]  == ({1'b0, key_far[2:0]} + 4'd4)) &&
                    (pix_y[3:0]   == {1'b0, ~key_far[2:0]});

  // Colour uses the pre-update frame count/LFSR, even on a frame_tick cycle.
  always_comb begin
    rgb_d = 6'b00_00_00;
    if (bg_en && video_active) begin
      if (hit_near) begin
        rgb_d = 6'b11_11_11;
      end else if (hit_far) begin
        // Twinkle: per-frame LFSR bit mixed with the cell key so neighbouring stars differ.
        rgb_d = (lfsr_q[0] ^ key_far[0]) ? 6'b01_01_01 : 6'b10_10_10;
      end else if (pix_y < SKY_SPLIT) begin
        rgb_d = 6'b00_00_01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      frame_cnt_q <= 10'd0;
      lfsr_q      <= LFSR_SEED;
      rgb_q       <= 6'b00_00_00;
    end else begin
      vsync_q     <= vsync;
      frame_cnt_q <= frame_cnt_d;
      lfsr_q      <= lfsr_d;
      rgb_q       <= rgb_d;
    end
  end

  assign R = rgb_q[5:4];
  assign G = rgb_q[3:2];
  assign B = rgb_q[1:0];

endmodule
